// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_t;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue/clear bundle between the pipeline (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = $clog2(RF_NREG),
    parameter int NRD  = 2,
    parameter int NWR  = 2
);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        input  rd_data, rd_busy, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        output rd_data, rd_busy, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks indices 1..NREG-1, one per cycle, then pulses clr_done.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = RF_NREG,
    localparam int AW  = $clog2(NREG)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_active,
    output logic [AW-1:0] clr_idx,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    clr_state_t    state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLR_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLR_CLEAR;
                        cnt      <= AW'(1);
                        clr_busy <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    // x0 is never stored, so the walk stops at the top index without wrapping
                    if (cnt == LAST_IDX) begin
                        state    <= CLR_DONE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                CLR_DONE: begin
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= CLR_IDLE;
                    cnt      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign clr_active = (state == CLR_CLEAR);
    assign clr_idx    = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV32 integer register file with write bypass, busy scoreboard and bulk clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREG   = RF_NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
)(
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    logic                      clr_active;
    logic [AW-1:0]             clr_idx;
    logic                      clr_busy;
    logic                      clr_done;

    regfile_clear_fsm #(.NREG(NREG)) u_clr (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (bus.clr_req),
        .clr_active (clr_active),
        .clr_idx    (clr_idx),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // Ascending port loop gives the highest write port the last word; the issue
    // update follows the writes so a fresh producer keeps its busy bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else if (clr_active) begin
            regs[clr_idx] <= '0;
            busy[clr_idx] <= 1'b0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.wr_en[k] && bus.wr_addr[k] != '0) begin
                    regs[bus.wr_addr[k]] <= bus.wr_data[k];
                    busy[bus.wr_addr[k]] <= 1'b0;
                end
            end
            if (bus.iss_en && bus.iss_addr != '0)
                busy[bus.iss_addr] <= 1'b1;
        end
    end

    logic [NRD-1:0][XLEN-1:0] rd_data_w;
    logic [NRD-1:0]           rd_busy_w;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [XLEN-1:0] d;
        logic            b;

        always_comb begin
            d = '0;
            b = 1'b0;
            if (rst && !clr_active && bus.rd_addr[g] != '0) begin
                d = regs[bus.rd_addr[g]];
                b = busy[bus.rd_addr[g]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (bus.wr_en[k] && bus.wr_addr[k] == bus.rd_addr[g]) begin
                            d = bus.wr_data[k];
                            b = 1'b0;
                        end
                    end
                end
            end
        end

        assign rd_data_w[g] = d;
        assign rd_busy_w[g] = b;
    end

    assign bus.rd_data = rd_data_w;
    assign bus.rd_busy = rd_busy_w;

endmodule

// File: tb/tb_regfile_mp.sv
// Random + directed bench for regfile_mp (bypass and non-bypass builds driven in lockstep).
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) bus  ();
    regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) bus0 ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    assign bus0.rd_addr  = bus.rd_addr;
    assign bus0.wr_en    = bus.wr_en;
    assign bus0.wr_addr  = bus.wr_addr;
    assign bus0.wr_data  = bus.wr_data;
    assign bus0.iss_en   = bus.iss_en;
    assign bus0.iss_addr = bus.iss_addr;
    assign bus0.clr_req  = bus.clr_req;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural contents, busy set, and cycles of clearing left.
    logic [XLEN-1:0] m_reg  [NREG];
    bit              m_busy [NREG];
    int              m_left = 0;
    bit              m_done = 0;

    always @(posedge clk or negedge rst) begin : mdl
        bit was_done;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_left = 0;
            m_done = 0;
        end else if (m_left > 0) begin
            m_reg[NREG - m_left]  = '0;
            m_busy[NREG - m_left] = 1'b0;
            m_left--;
            m_done = (m_left == 0);
        end else begin
            was_done = m_done;
            m_done   = 0;
            for (int k = 0; k < NWR; k++)
                if (bus.wr_en[k] && bus.wr_addr[k] != 0) begin
                    m_reg[bus.wr_addr[k]]  = bus.wr_data[k];
                    m_busy[bus.wr_addr[k]] = 1'b0;
                end
            if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
            if (bus.clr_req && !was_done) m_left = NREG - 1;
        end
    end

    function automatic void exp_rd(input int p, input bit byp,
                                   output logic [31:0] d, output logic b);
        int a;
        a = int'(bus.rd_addr[p]);
        d = '0;
        b = 1'b0;
        if (!rst || m_left > 0 || a == 0) return;
        d = m_reg[a];
        b = m_busy[a];
        if (byp)
            for (int k = 0; k < NWR; k++)
                if (bus.wr_en[k] && int'(bus.wr_addr[k]) == a) begin
                    d = bus.wr_data[k];
                    b = 1'b0;
                end
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] d;
        logic        b;
        for (int p = 0; p < NRD; p++) begin
            exp_rd(p, 1'b1, d, b);
            check($sformatf("rd_data[%0d]", p), bus.rd_data[p], d);
            check($sformatf("rd_busy[%0d]", p), 32'(bus.rd_busy[p]), 32'(b));
            exp_rd(p, 1'b0, d, b);
            check($sformatf("nobyp_rd_data[%0d]", p), bus0.rd_data[p], d);
            check($sformatf("nobyp_rd_busy[%0d]", p), 32'(bus0.rd_busy[p]), 32'(b));
        end
        check("clr_busy", 32'(bus.clr_busy), 32'(m_left > 0));
        check("clr_done", 32'(bus.clr_done), 32'(m_done));
        check("nobyp_clr_busy", 32'(bus0.clr_busy), 32'(m_left > 0));
        check("nobyp_clr_done", 32'(bus0.clr_done), 32'(m_done));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = '0;
        bus.iss_en  = 1'b0;
        bus.clr_req = 1'b0;
    endtask

    initial begin : stim
        int nbusy, ndone;
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.clr_req  = 1'b0;
        #1 rst = 1'b0;

        // writes and issues while in reset must stay invisible
        bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'h1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd5; bus.rd_addr[0] = 5'd5;
        #1 check("rst_rd_data", bus.rd_data[0], 32'h0);
        repeat (3) cyc();
        check("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
        idle();
        rst = 1'b1;

        for (int a = 0; a < NREG; a++) begin
            bus.rd_addr[0] = AW'(a);
            bus.rd_addr[1] = AW'(NREG - 1 - a);
            #1;
            check("init_rd0", bus.rd_data[0], 32'h0);
            check("init_rd1", bus.rd_data[1], 32'h0);
            check("init_busy", 32'(bus.rd_busy), 32'h0);
            cyc();
        end

        // both write ports hit x5: port 1 wins, bypass visible only on the bypass build
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'hDEADBEEF;
        bus.wr_addr[1] = 5'd5; bus.wr_data[1] = 32'h12345678;
        bus.rd_addr[0] = 5'd5;
        #1;
        check("byp_same_cycle", bus.rd_data[0], 32'h12345678);
        check("nobyp_same_cycle", bus0.rd_data[0], 32'h0);
        cyc(); idle(); #1;
        check("byp_next_cycle", bus.rd_data[0], 32'h12345678);
        check("nobyp_next_cycle", bus0.rd_data[0], 32'h12345678);

        // x0 ignores writes and issues
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'hFFFFFFFF;
        bus.rd_addr[0] = 5'd0;
        #1 check("x0_bypass", bus.rd_data[0], 32'h0);
        cyc(); idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        cyc(); idle(); #1;
        check("x0_data", bus.rd_data[0], 32'h0);
        check("x0_busy", 32'(bus.rd_busy[0]), 32'h0);

        // scoreboard on x7
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        cyc(); idle(); bus.rd_addr[0] = 5'd7; #1;
        check("x7_busy_after_iss", 32'(bus.rd_busy[0]), 32'h1);
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'hA5;
        #1;
        check("x7_byp_busy", 32'(bus.rd_busy[0]), 32'h0);
        check("x7_byp_data", bus.rd_data[0], 32'hA5);
        cyc(); idle(); #1;
        check("x7_busy_after_wr", 32'(bus.rd_busy[0]), 32'h0);
        check("x7_data_after_wr", bus.rd_data[0], 32'hA5);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'hA5;
        cyc(); idle(); #1;
        check("x7_iss_wr_busy", 32'(bus.rd_busy[0]), 32'h1);
        check("x7_iss_wr_data", bus.rd_data[0], 32'hA5);

        // non-bypass build returns the stored value during a write
        bus.wr_en = 2'b10; bus.wr_addr[1] = 5'd9; bus.wr_data[1] = 32'h1111;
        cyc();
        bus.wr_data[1] = 32'h2222; bus.rd_addr[1] = 5'd9;
        #1;
        check("x9_nobyp_old", bus0.rd_data[1], 32'h1111);
        check("x9_byp_new", bus.rd_data[1], 32'h2222);
        cyc(); idle();

        // fill, mark x3 busy, then bulk clear while hammering ignored inputs
        for (int i = 1; i < NREG; i++) begin
            bus.wr_en = 2'b10; bus.wr_addr[1] = AW'(i); bus.wr_data[1] = 32'(i);
            cyc();
        end
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        cyc(); idle();
        bus.rd_addr[0] = 5'd31; bus.rd_addr[1] = 5'd3; #1;
        check("fill_x31", bus.rd_data[0], 32'd31);
        check("fill_x3_busy", 32'(bus.rd_busy[1]), 32'h1);
        bus.clr_req = 1'b1;
        cyc();
        nbusy = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.clr_busy) nbusy++;
            if (bus.clr_done) ndone++;
            bus.clr_req = bus.clr_busy | bus.clr_done;
            bus.wr_en   = bus.clr_busy ? 2'b11 : 2'b00;
            bus.wr_addr[0] = 5'd10; bus.wr_data[0] = 32'hBAD;
            bus.wr_addr[1] = 5'd11; bus.wr_data[1] = 32'hBAD;
            bus.iss_en  = bus.clr_busy; bus.iss_addr = 5'd12;
            cyc();
        end
        idle();
        check("clear_busy_cycles", 32'(nbusy), 32'd31);
        check("clear_done_pulses", 32'(ndone), 32'd1);
        for (int a = 0; a < NREG; a++) begin
            bus.rd_addr[0] = AW'(a);
            bus.rd_addr[1] = AW'(a);
            #1;
            check("post_clear_data", bus.rd_data[0], 32'h0);
            check("post_clear_busy", 32'(bus.rd_busy[1]), 32'h0);
            cyc();
        end

        // reset in the middle of a clear: no done pulse, everything zero
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd4; bus.wr_data[0] = 32'd44;
        cyc(); idle();
        bus.clr_req = 1'b1;
        cyc(); idle();
        repeat (10) cyc();
        #2 rst = 1'b0;
        #1 check("mid_rst_clr_busy", 32'(bus.clr_busy), 32'h0);
        repeat (2) cyc();
        rst = 1'b1;
        nbusy = 0; ndone = 0;
        bus.rd_addr[0] = 5'd4;
        for (int c = 0; c < 40; c++) begin
            if (bus.clr_busy) nbusy++;
            if (bus.clr_done) ndone++;
            cyc();
        end
        check("mid_rst_no_busy", 32'(nbusy), 32'd0);
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        check("mid_rst_x4", bus.rd_data[0], 32'h0);

        // randomized traffic with address bias toward collisions
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NRD; p++)
                bus.rd_addr[p] = AW'($urandom_range(0, NREG - 1));
            for (int k = 0; k < NWR; k++) begin
                bus.wr_en[k]   = 1'($urandom_range(0, 1));
                bus.wr_addr[k] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                             : AW'($urandom_range(0, NREG - 1));
                bus.wr_data[k] = $urandom;
            end
            bus.iss_en   = ($urandom_range(0, 3) == 0);
            bus.iss_addr = AW'($urandom_range(0, 7));
            bus.clr_req  = ($urandom_range(0, 99) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
